// File: rtl/regarb_pkg.sv
// Shared widths, FSM state encoding and helpers for the register-write arbiter.
package regarb_pkg;

  localparam int DW_DEF = 8;
  localparam int AW_DEF = 2;
  localparam int CNT_W  = 8;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_WRITE = 1'b1
  } state_t;

  // Population count of up to four request lines.
  function automatic logic [2:0] popcnt4(input logic [3:0] v);
    popcnt4 = 3'(v[0]) + 3'(v[1]) + 3'(v[2]) + 3'(v[3]);
  endfunction

endpackage

// File: rtl/regwr_arbiter_rr_pick.sv
// Combinational round-robin picker: first eligible requester after ptr, wrapping.
module rr_pick #(
  parameter int NREQ = 3,
  parameter int PW   = 2
) (
  input  logic [NREQ-1:0] eligible,
  input  logic [PW-1:0]   ptr,
  output logic [PW-1:0]   winner,
  output logic            any_valid
);

  logic found_s;
  int   idx_s;

  // Scan from ptr+1 upward; the first hit wins.
  always_comb begin
    winner  = '0;
    found_s = 1'b0;
    idx_s   = 0;
    for (int k = 1; k <= NREQ; k++) begin
      idx_s = (int'(ptr) + k) % NREQ;
      if (!found_s && eligible[PW'(idx_s)]) begin
        winner  = PW'(idx_s);
        found_s = 1'b1;
      end else begin
        found_s = found_s;
      end
    end
  end

  assign any_valid = |eligible;

endmodule

// File: rtl/regwr_arbiter.sv
// Round-robin write-port arbiter feeding a bank of enable-load registers.
// Optional conflict counter output enabled by macro REGARB_CNT_EN.
module regwr_arbiter
  import regarb_pkg::*;
#(
  parameter int NREQ = 3,
  parameter int NREG = 4,
  parameter int AW   = AW_DEF,
  parameter int DW   = DW_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [NREQ-1:0]  req,
  input  logic [NREQ*AW-1:0] req_addr,
  input  logic [NREQ*DW-1:0] req_data,
  output logic [NREQ-1:0]  gnt,
  output logic [NREG-1:0]  reg_ena,
  output logic [DW-1:0]    reg_data,
  output logic             busy,
`ifdef REGARB_CNT_EN
  output logic             addr_err,
  output logic [CNT_W-1:0] conflict_cnt
`else
  output logic             addr_err
`endif
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  state_t          state_r, state_nx_s;
  logic [NREQ-1:0] gnt_r, gnt_nx_s;
  logic [NREG-1:0] ena_r, ena_nx_s;
  logic [DW-1:0]   data_r, data_nx_s;
  logic            err_r, err_nx_s;
  logic [PW-1:0]   ptr_r, ptr_nx_s;
  logic [NREQ-1:0] eligible_s;
  logic [PW-1:0]   winner_s;
  logic            any_s;
  logic [AW-1:0]   win_addr_s;
  logic [DW-1:0]   win_data_s;

  // The requester granted this cycle sits out the next arbitration.
  assign eligible_s = req & ~gnt_r;

  rr_pick #(.NREQ(NREQ), .PW(PW)) u_pick (
    .eligible  (eligible_s),
    .ptr       (ptr_r),
    .winner    (winner_s),
    .any_valid (any_s)
  );

  assign win_addr_s = req_addr[int'(winner_s)*AW +: AW];
  assign win_data_s = req_data[int'(winner_s)*DW +: DW];

  // Next-state and next-output decode.
  always_comb begin
    state_nx_s = ST_IDLE;
    gnt_nx_s   = '0;
    ena_nx_s   = '0;
    data_nx_s  = data_r;
    err_nx_s   = 1'b0;
    ptr_nx_s   = ptr_r;
    case (state_r)
      ST_IDLE:  state_nx_s = any_s ? ST_WRITE : ST_IDLE;
      ST_WRITE: state_nx_s = any_s ? ST_WRITE : ST_IDLE;
      default:  state_nx_s = ST_IDLE;
    endcase
    if (any_s) begin
      gnt_nx_s[winner_s] = 1'b1;
      for (int r = 0; r < NREG; r++) begin
        ena_nx_s[r] = (int'(win_addr_s) == r);
      end
      data_nx_s = win_data_s;
      err_nx_s  = (int'(win_addr_s) >= NREG);
      ptr_nx_s  = winner_s;
    end else begin
      ptr_nx_s = ptr_r;
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nx_s;
    end
  end

  // Registered grant, bank drive and pointer.
  always_ff @(posedge clk) begin
    if (!rst) begin
      gnt_r  <= '0;
      ena_r  <= '0;
      data_r <= '0;
      err_r  <= 1'b0;
      ptr_r  <= PW'(NREQ - 1);
    end else begin
      gnt_r  <= gnt_nx_s;
      ena_r  <= ena_nx_s;
      data_r <= data_nx_s;
      err_r  <= err_nx_s;
      ptr_r  <= ptr_nx_s;
    end
  end

  assign gnt      = gnt_r;
  assign reg_ena  = ena_r;
  assign reg_data = data_r;
  assign addr_err = err_r;
  assign busy     = (state_r == ST_WRITE);

`ifdef REGARB_CNT_EN
  logic [CNT_W-1:0] cnt_r;
  logic [2:0]       pc_s;

  assign pc_s = popcnt4(4'(eligible_s));

  // Saturating count of cycles with two or more contenders.
  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_r <= '0;
    end else if ((pc_s >= 3'd2) && (cnt_r != 8'hFF)) begin
      cnt_r <= cnt_r + 8'd1;
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign conflict_cnt = cnt_r;
`endif

endmodule

// File: tb/tb_regwr_arbiter.sv
// Self-checking bench: spec-level model checked every cycle plus directed literals.
module tb_regwr_arbiter;

  localparam int NREQ = 3;
  localparam int AW   = 2;
  localparam int DW   = 8;

  logic clk = 1'b0;
  logic rst;
  logic [NREQ-1:0]    req;
  logic [NREQ*AW-1:0] req_addr;
  logic [NREQ*DW-1:0] req_data;

  logic [2:0] gnt_a, gnt_b;
  logic [3:0] ena_a;
  logic [2:0] ena_b;
  logic [7:0] rdata_a, rdata_b;
  logic       busy_a, busy_b, err_a, err_b;
`ifdef REGARB_CNT_EN
  logic [7:0] cnt_a, cnt_b;
`endif

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  regwr_arbiter #(.NREQ(3), .NREG(4)) dut_a (
    .clk(clk), .rst(rst), .req(req), .req_addr(req_addr), .req_data(req_data),
    .gnt(gnt_a), .reg_ena(ena_a), .reg_data(rdata_a), .busy(busy_a),
`ifdef REGARB_CNT_EN
    .addr_err(err_a), .conflict_cnt(cnt_a)
`else
    .addr_err(err_a)
`endif
  );

  regwr_arbiter #(.NREQ(3), .NREG(3)) dut_b (
    .clk(clk), .rst(rst), .req(req), .req_addr(req_addr), .req_data(req_data),
    .gnt(gnt_b), .reg_ena(ena_b), .reg_data(rdata_b), .busy(busy_b),
`ifdef REGARB_CNT_EN
    .addr_err(err_b), .conflict_cnt(cnt_b)
`else
    .addr_err(err_b)
`endif
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model state, index 0 = dut_a (NREG=4), 1 = dut_b (NREG=3)
  int m_ptr [2];
  int m_last [2];
  int exp_gnt [2], exp_ena [2], exp_data [2], exp_busy [2], exp_err [2];
  int exp_cnt;
  bit started = 1'b0;

  task automatic model_step(input int d, input int nreg);
    int win, cnt, a;
    if (!rst) begin
      m_ptr[d] = NREQ - 1; m_last[d] = -1;
      exp_gnt[d] = 0; exp_ena[d] = 0; exp_data[d] = 0; exp_busy[d] = 0; exp_err[d] = 0;
      if (d == 0) exp_cnt = 0;
    end else begin
      win = -1; cnt = 0;
      for (int k = 1; k <= NREQ; k++) begin
        int i;
        i = (m_ptr[d] + k) % NREQ;
        if (req[i] && i != m_last[d]) begin
          cnt++;
          if (win < 0) win = i;
        end
      end
      if (d == 0 && cnt >= 2 && exp_cnt < 255) exp_cnt++;
      if (win < 0) begin
        exp_gnt[d] = 0; exp_ena[d] = 0; exp_err[d] = 0; exp_busy[d] = 0; m_last[d] = -1;
      end else begin
        a = int'((req_addr >> (win * AW)) & 6'h3);
        exp_gnt[d]  = 1 << win;
        exp_ena[d]  = (a < nreg) ? (1 << a) : 0;
        exp_data[d] = int'((req_data >> (win * DW)) & 24'hFF);
        exp_err[d]  = (a >= nreg) ? 1 : 0;
        exp_busy[d] = 1;
        m_ptr[d] = win; m_last[d] = win;
      end
    end
  endtask

  // Model advance at each edge, then compare both DUTs just after it.
  always @(posedge clk) begin
    model_step(0, 4);
    model_step(1, 3);
    if (!rst) started = 1'b1;
    #1;
    if (started) begin
      chk("m_gnt_a", 32'(gnt_a), exp_gnt[0]);
      chk("m_ena_a", 32'(ena_a), exp_ena[0]);
      chk("m_data_a", 32'(rdata_a), exp_data[0]);
      chk("m_busy_a", 32'(busy_a), exp_busy[0]);
      chk("m_err_a", 32'(err_a), exp_err[0]);
      chk("m_gnt_b", 32'(gnt_b), exp_gnt[1]);
      chk("m_ena_b", 32'(ena_b), exp_ena[1]);
      chk("m_data_b", 32'(rdata_b), exp_data[1]);
      chk("m_busy_b", 32'(busy_b), exp_busy[1]);
      chk("m_err_b", 32'(err_b), exp_err[1]);
`ifdef REGARB_CNT_EN
      chk("m_cnt_a", 32'(cnt_a), exp_cnt);
`endif
    end
  end

  // Stand-in register bank loaded from dut_a.
  logic [7:0] bank_a [4];
  always @(posedge clk) begin
    for (int r = 0; r < 4; r++) if (ena_a[r]) bank_a[r] <= rdata_a;
  end

  task automatic set_req(input int i, input logic [1:0] a, input logic [7:0] d);
    req_addr[i*AW +: AW] = a;
    req_data[i*DW +: DW] = d;
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  logic [2:0] seq_g [6];
  logic [3:0] seq_e [6];

  initial begin
    rst = 1'b0; req = 3'b000; req_addr = '0; req_data = '0;
    cyc(2);
    chk("rst_gnt", 32'(gnt_a), 32'd0);
    chk("rst_busy", 32'(busy_a), 32'd0);
    chk("rst_data", 32'(rdata_a), 32'd0);
    rst = 1'b1;

    // single request
    set_req(0, 2'd2, 8'hA5); req = 3'b001;
    cyc(1);
    chk("t1_gnt", 32'(gnt_a), 32'h1);
    chk("t1_ena", 32'(ena_a), 32'h4);
    chk("t1_data", 32'(rdata_a), 32'hA5);
    chk("t1_busy", 32'(busy_a), 32'd1);
    req = 3'b000;
    cyc(1);
    chk("t1_gnt_off", 32'(gnt_a), 32'd0);
    chk("t1_ena_off", 32'(ena_a), 32'd0);
    chk("t1_data_hold", 32'(rdata_a), 32'hA5);

    // all three continuously; ptr is at 0 so requester 1 leads
    set_req(0, 2'd0, 8'h11); set_req(1, 2'd1, 8'h22); set_req(2, 2'd2, 8'h33);
    req = 3'b111;
    seq_g = '{3'b010, 3'b100, 3'b001, 3'b010, 3'b100, 3'b001};
    seq_e = '{4'b0010, 4'b0100, 4'b0001, 4'b0010, 4'b0100, 4'b0001};
    for (int i = 0; i < 6; i++) begin
      cyc(1);
      chk("t2_gnt", 32'(gnt_a), 32'(seq_g[i]));
      chk("t2_ena", 32'(ena_a), 32'(seq_e[i]));
    end
    req = 3'b000;
    cyc(1);

    // lone requester 1 gets every other cycle
    req = 3'b010;
    for (int i = 0; i < 6; i++) begin
      cyc(1);
      chk("t3_busy", 32'(busy_a), (i % 2 == 0) ? 32'd1 : 32'd0);
      chk("t3_gnt1", 32'(gnt_a[1]), (i % 2 == 0) ? 32'd1 : 32'd0);
    end
    req = 3'b000;

    // out-of-range address on the NREG=3 instance
    set_req(0, 2'd3, 8'h77); req = 3'b001;
    cyc(1);
    chk("t4_gnt_b", 32'(gnt_b), 32'h1);
    chk("t4_ena_b", 32'(ena_b), 32'h0);
    chk("t4_err_b", 32'(err_b), 32'd1);
    chk("t4_ena_a", 32'(ena_a), 32'h8);
    chk("t4_err_a", 32'(err_a), 32'd0);
    req = 3'b000;
    cyc(1);
    chk("t4_err_b_off", 32'(err_b), 32'd0);

    // reset while requester 1 is granted
    req = 3'b111;
    cyc(1);
    chk("t5_gnt_pre", 32'(gnt_a), 32'h2);
    rst = 1'b0;
    cyc(1);
    chk("t5_gnt_rst", 32'(gnt_a), 32'd0);
    chk("t5_ena_rst", 32'(ena_a), 32'd0);
    chk("t5_busy_rst", 32'(busy_a), 32'd0);
    chk("t5_data_rst", 32'(rdata_a), 32'd0);
    rst = 1'b1;
    cyc(1);
    chk("t5_first_win", 32'(gnt_a), 32'h1);
    req = 3'b000;
    cyc(1);

    // two writers to one address: grant order 2 then 0
    set_req(0, 2'd1, 8'h5A); set_req(2, 2'd1, 8'hC3);
    req = 3'b101;
    cyc(1);
    chk("t6_gnt_first", 32'(gnt_a), 32'h4);
    chk("t6_data_first", 32'(rdata_a), 32'hC3);
    req = 3'b001;
    cyc(1);
    chk("t6_gnt_second", 32'(gnt_a), 32'h1);
    chk("t6_data_second", 32'(rdata_a), 32'h5A);
    req = 3'b000;
    cyc(1);
    chk("t6_bank_last", 32'(bank_a[1]), 32'h5A);

    // long contention run
    set_req(0, 2'd0, 8'h01); set_req(1, 2'd1, 8'h02); set_req(2, 2'd2, 8'h03);
    req = 3'b111;
    cyc(300);
`ifdef REGARB_CNT_EN
    chk("t7_cnt_sat", 32'(cnt_a), 32'hFF);
`endif
    req = 3'b000;
    cyc(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
